layer_mac_sequencer: RTL and testbench

- Time-multiplexed scheduler for one fully-connected layer. A single shared 8x8 signed MAC evaluates N_OUT neurons of N_IN inputs each, one neuron after another.
- Weights and biases come from external synchronous memories with 1-cycle read latency. Activations are preloaded into an internal buffer.
- Each neuron result uses the layer quantisation: bias add, ReLU, round, saturate. Results stream out on a valid/ready port.

---
 rtl/layer_mac_sequencer.sv | 150 +++++++++++++++
 tb/tb_layer_mac_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mac_sequencer.sv
// Evaluates one fully-connected layer neuron by neuron on a single shared
// 8x8 signed MAC. Bias and weights are fetched from external synchronous
// memories (1-cycle latency); activations are preloaded into a local buffer.
// Each neuron result is quantised (bias, ReLU, round, saturate) and streamed
// out on a valid/ready port.
module layer_mac_sequencer #(
  parameter int N_IN  = 30,
  parameter int N_OUT = 16,
  parameter int W_AW  = 9,
  parameter int B_AW  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               act_wr_en,
  input  logic [4:0]         act_wr_idx,
  input  logic signed [7:0]  act_wr_data,
  output logic               w_rd_en,
  output logic [W_AW-1:0]    w_addr,
  input  logic signed [7:0]  w_data,
  output logic               b_rd_en,
  output logic [B_AW-1:0]    b_addr,
  input  logic signed [15:0] b_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [B_AW-1:0]    out_idx,
  output logic [7:0]         out_data
);

  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, ACT, OUT} state_t;

  localparam logic [4:0]      K_LAST = 5'(N_IN - 1);
  localparam logic [4:0]      K_END  = 5'(N_IN);
  localparam logic [B_AW-1:0] N_LAST = B_AW'(N_OUT - 1);

  state_t             state, next_state;
  logic [B_AW-1:0]    neuron;
  logic [4:0]         k;
  logic signed [22:0] acc;
  logic signed [7:0]  act_buf [N_IN];
  logic signed [7:0]  act_sel;
  logic signed [15:0] prod;
  logic [7:0]         rnd;
  logic [7:0]         q_data;

  assign busy = (state != IDLE);

  // Activation buffer: writable only while idle so it is frozen for a layer.
  // NOTE: this buffer is small register storage with a defined cleared state,
  // so it is reset explicitly; a RAM macro would not be.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) act_buf[i] <= '0;
    end else if (act_wr_en && !busy && (act_wr_idx < K_END)) begin
      act_buf[act_wr_idx] <= act_wr_data;
    end
  end

  // Activation paired with the weight arriving this cycle (read issued at k-1).
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    act_sel = '0;
    if ((k != '0) && (k <= K_END)) act_sel = act_buf[k - 5'd1];
  end

  assign prod = w_data * act_sel;

  // Quantiser: ReLU, saturate above 127, round half up on bit 5.
  always_comb begin
    rnd    = acc[13:6] + {7'd0, acc[5]};
    q_data = rnd;
    if (acc[22])          q_data = 8'd0;
    else if (|acc[21:13]) q_data = 8'd127;
    else if (rnd[7])      q_data = 8'd127;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and memory read strobes / addresses.
  always_comb begin
    next_state = state;
    w_rd_en    = 1'b0;
    b_rd_en    = 1'b0;
    w_addr     = '0;
    b_addr     = '0;
    case (state)
      IDLE:  if (start) next_state = BIAS;
      BIAS: begin
        b_rd_en    = 1'b1;
        b_addr     = neuron;
        next_state = MAC;
      end
      MAC: begin
        w_rd_en = 1'b1;
        w_addr  = W_AW'(int'(neuron) * N_IN + int'(k));
        if (k == K_LAST) next_state = DRAIN;
      end
      DRAIN: next_state = ACT;
      ACT:   next_state = OUT;
      OUT:   if (out_ready) next_state = (neuron == N_LAST) ? IDLE : BIAS;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: counters, accumulator, result register and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      neuron    <= '0;
      k         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) neuron <= '0;
        BIAS: k <= '0;
        MAC: begin
          k <= k + 5'd1;
          if (k == '0) acc <= {{7{b_data[15]}}, b_data};
          else         acc <= acc + {{7{prod[15]}}, prod};
        end
        DRAIN: acc <= acc + {{7{prod[15]}}, prod};
        ACT: begin
          out_data  <= q_data;
          out_idx   <= neuron;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (neuron == N_LAST) done   <= 1'b1;
          else                  neuron <= neuron + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Self-checking bench for layer_mac_sequencer: behavioural weight/bias
// memories, a reference model feeding a result scoreboard, and one task per
// scenario.
module tb_layer_mac_sequencer;

  localparam int N_IN  = 30;
  localparam int N_OUT = 16;
  localparam int W_AW  = 9;
  localparam int B_AW  = 4;

  typedef struct {
    int idx;
    int data;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                busy;
  logic                done;
  logic                act_wr_en;
  logic [4:0]          act_wr_idx;
  logic signed [7:0]   act_wr_data;
  logic                w_rd_en;
  logic [W_AW-1:0]     w_addr;
  logic signed [7:0]   w_data;
  logic                b_rd_en;
  logic [B_AW-1:0]     b_addr;
  logic signed [15:0]  b_data;
  logic                out_valid;
  logic                out_ready;
  logic [B_AW-1:0]     out_idx;
  logic [7:0]          out_data;

  logic signed [7:0]   wmem  [N_IN*N_OUT];
  logic signed [15:0]  bmem  [N_OUT];
  logic signed [7:0]   act_m [N_IN];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  layer_mac_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .W_AW(W_AW), .B_AW(B_AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .act_wr_en(act_wr_en), .act_wr_idx(act_wr_idx), .act_wr_data(act_wr_data),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data)
  );

  // Synchronous read memories with one cycle of latency.
  always @(posedge clk) begin
    if (w_rd_en) w_data <= wmem[w_addr];
    if (b_rd_en) b_data <= bmem[b_addr];
  end

  // Reference: exact integer dot product, then ReLU / round-half-up / clamp.
  function automatic int model(input int n);
    int acc;
    int r;
    acc = int'(bmem[n]);
    for (int k = 0; k < N_IN; k++) acc += int'(wmem[n*N_IN+k]) * int'(act_m[k]);
    if (acc < 0) return 0;
    if (acc >= 8192) return 127;
    r = (acc + 32) / 64;
    return (r > 127) ? 127 : r;
  endfunction

  // Read-port rules while busy, and scoreboard pop on every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      if (busy === 1'b1) begin
        checks++;
        if (w_rd_en === 1'b1 && (b_rd_en === 1'b1 || int'(w_addr) >= N_IN*N_OUT)) begin
          errors++;
          $display("FAIL rd_port w_rd_en=%b b_rd_en=%b w_addr=%0d (need exclusive strobes, addr<%0d)",
                   w_rd_en, b_rd_en, w_addr, N_IN*N_OUT);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result idx=%0d data=%0d (no result expected)", out_idx, out_data);
        end else begin
          e = sb.pop_front();
          if (out_idx !== B_AW'(e.idx) || out_data !== 8'(e.data)) begin
            errors++;
            $display("FAIL result idx=%0d data=%0d expected idx=%0d data=%0d",
                     out_idx, out_data, e.idx, e.data);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = '0;
    for (int n = 0; n < N_OUT; n++) bmem[n] = '0;
    for (int i = 0; i < N_IN; i++) act_m[i] = '0;
  endtask

  // Writes act_m into the DUT buffer; optionally leaves index 0 for later.
  task automatic write_acts(input bit skip0);
    for (int i = (skip0 ? 1 : 0); i < N_IN; i++) begin
      act_wr_en   = 1'b1;
      act_wr_idx  = 5'(i);
      act_wr_data = act_m[i];
      tick();
    end
    act_wr_en = 1'b0;
  endtask

  // Pulses start (optionally with the act[0] write in the same cycle) and
  // returns the number of edges, counting the one that samples start, until
  // out_valid is seen.
  task automatic start_layer(input bit with_write, output int lat);
    for (int n = 0; n < N_OUT; n++) sb.push_back('{n, model(n)});
    start = 1'b1;
    if (with_write) begin
      act_wr_en   = 1'b1;
      act_wr_idx  = 5'd0;
      act_wr_data = act_m[0];
    end
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      start     = 1'b0;
      act_wr_en = 1'b0;
      @(negedge clk);
    end while (out_valid !== 1'b1 && lat < 200);
    if (lat >= 200) begin
      checks++;
      errors++;
      $display("FAIL first_valid_timeout waited=%0d edges", lat);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_done_timeout waited=%0d cycles", name, n);
    end else begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy_at_done busy=%b expected 0", name, busy);
      end
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL %s_results_before_done pending=%0d expected 0", name, sb.size());
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s_done_width done=%b expected 0", name, done);
      end
    end
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    start       = 1'b0;
    act_wr_en   = 1'b0;
    act_wr_idx  = '0;
    act_wr_data = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, out_valid, w_rd_en, b_rd_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b valid=%b w_rd=%b b_rd=%b expected all 0",
               busy, done, out_valid, w_rd_en, b_rd_en);
    end
    checks++;
    if (out_idx !== '0 || out_data !== '0 || w_addr !== '0 || b_addr !== '0) begin
      errors++;
      $display("FAIL reset_values idx=%0d data=%0d w_addr=%0d b_addr=%0d expected all 0",
               out_idx, out_data, w_addr, b_addr);
    end
  endtask

  task automatic test_zero_acts;
    int lat;
    clear_model();
    for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = 8'($urandom);
    for (int n = 0; n < N_OUT; n++) bmem[n] = -16'sd512;
    write_acts(1'b0);
    out_ready = 1'b1;
    start_layer(1'b0, lat);
    wait_done("zero_acts");
  endtask

  task automatic load_single_tap;
    clear_model();
    act_m[0] = 8'sd64;
    for (int n = 0; n < N_OUT; n++) wmem[n*N_IN] = 8'sd64;
  endtask

  task automatic test_latency;
    int lat;
    int gap;
    load_single_tap();
    write_acts(1'b0);
    out_ready = 1'b1;
    start_layer(1'b0, lat);
    checks++;
    if (lat != N_IN + 4) begin
      errors++;
      $display("FAIL first_latency got=%0d expected=%0d", lat, N_IN + 4);
    end
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (out_valid !== 1'b1 && gap < 100);
    checks++;
    if (gap != N_IN + 4) begin
      errors++;
      $display("FAIL result_spacing got=%0d expected=%0d", gap, N_IN + 4);
    end
    wait_done("latency");
  endtask

  task automatic test_rounding;
    int lat;
    clear_model();
    act_m[0] = 8'sd32;
    wmem[0]  = 8'sd3;           // acc = 96  -> 2
    bmem[1]  = 16'sd8191;       // r = 128   -> 127
    bmem[2]  = -16'sd1;         // negative  -> 0
    for (int n = 3; n < N_OUT; n++) begin
      wmem[n*N_IN] = 8'($urandom);
      bmem[n]      = 16'($urandom_range(0, 12000)) - 16'sd4000;
    end
    write_acts(1'b0);
    out_ready = 1'b1;
    start_layer(1'b0, lat);
    wait_done("rounding");
  endtask

  task automatic test_saturation;
    int lat;
    clear_model();
    for (int i = 0; i < N_IN; i++) act_m[i] = 8'sd127;
    for (int n = 0; n < N_OUT; n++)
      for (int k = 0; k < N_IN; k++) wmem[n*N_IN+k] = (n % 2 == 0) ? 8'sd127 : -8'sd127;
    write_acts(1'b0);
    out_ready = 1'b1;
    start_layer(1'b0, lat);
    wait_done("saturation");
  endtask

  task automatic test_backpressure;
    int lat;
    int n;
    logic [B_AW-1:0] idx0;
    logic [7:0]      data0;
    clear_model();
    for (int i = 0; i < N_IN; i++) act_m[i] = 8'($urandom);
    for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = 8'($urandom);
    for (int j = 0; j < N_OUT; j++) bmem[j] = 16'($urandom);
    write_acts(1'b0);
    out_ready = 1'b1;
    start_layer(1'b0, lat);
    n = 0;
    while (!(b_rd_en === 1'b1 && b_addr === 4'd3) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    idx0  = out_idx;
    data0 = out_data;
    checks++;
    if (out_valid !== 1'b1 || idx0 !== 4'd3) begin
      errors++;
      $display("FAIL bp_stall_point valid=%b idx=%0d expected valid=1 idx=3", out_valid, idx0);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== idx0 || out_data !== data0 || w_rd_en !== 1'b0 || b_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d valid=%b idx=%0d data=%0d w_rd=%b b_rd=%b expected 1/%0d/%0d/0/0",
                 c, out_valid, out_idx, out_data, w_rd_en, b_rd_en, idx0, data0);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (b_rd_en !== 1'b1 || b_addr !== 4'd4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_bias b_rd=%b b_addr=%0d valid=%b expected 1/4/0", b_rd_en, b_addr, out_valid);
    end
    wait_done("backpressure");
  endtask

  task automatic test_reset_mid;
    int lat;
    int n;
    load_single_tap();
    write_acts(1'b0);
    out_ready = 1'b1;
    start_layer(1'b0, lat);
    n = 0;
    while (!(w_rd_en === 1'b1 && w_addr === 9'd70) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL rst_mid_reach w_addr=%0d never reached 70", w_addr);
    end
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state busy=%b valid=%b done=%b expected 0/0/0", busy, out_valid, done);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_quiet cycle=%0d done=%b busy=%b expected 0/0", c, done, busy);
      end
    end
    // Reset cleared the activation buffer, so every neuron sees zero inputs.
    act_m[0] = 8'sd0;
    start_layer(1'b0, lat);
    wait_done("rst_cleared_acts");
    // Re-preload with act[0] written in the same cycle as start.
    act_m[0] = 8'sd64;
    write_acts(1'b1);
    start_layer(1'b1, lat);
    checks++;
    if (lat != N_IN + 4) begin
      errors++;
      $display("FAIL rst_restart_latency got=%0d expected=%0d", lat, N_IN + 4);
    end
    // start and a buffer write while busy must both be ignored.
    repeat (5) tick();
    start       = 1'b1;
    act_wr_en   = 1'b1;
    act_wr_idx  = 5'd0;
    act_wr_data = -8'sd128;
    tick();
    start     = 1'b0;
    act_wr_en = 1'b0;
    wait_done("busy_ignore");
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_ignore_restart busy=%b expected 0", busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_acts();
    test_latency();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
